// File: rtl/screen_pkg.sv
// Shared colour layout, fade state encoding and colour-word unpacking helpers
// for the screen fade multiplexer.
package screen_pkg;

    localparam int RED_W   = 3;
    localparam int GREEN_W = 3;
    localparam int BLUE_W  = 2;
    localparam int COLOR_W = RED_W + GREEN_W + BLUE_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    // A colour word is packed {R, G, B} with red in the most significant bits.
    function automatic logic [RED_W-1:0] red_of(input logic [COLOR_W-1:0] color);
        return color[BLUE_W+GREEN_W +: RED_W];
    endfunction

    function automatic logic [GREEN_W-1:0] green_of(input logic [COLOR_W-1:0] color);
        return color[BLUE_W +: GREEN_W];
    endfunction

    function automatic logic [BLUE_W-1:0] blue_of(input logic [COLOR_W-1:0] color);
        return color[BLUE_W-1:0];
    endfunction

endpackage

// File: rtl/color_scaler.sv
// Scales one colour channel by a brightness level in 0..2**LEVEL_W.
// The top level value passes the channel through unchanged, zero gives black,
// everything in between rounds down.
module color_scaler #(
    parameter int CHAN_W  = 3,
    parameter int LEVEL_W = 3
) (
    input  logic [CHAN_W-1:0]  chan,
    input  logic [LEVEL_W:0]   level,
    output logic [CHAN_W-1:0]  scaled
);

    logic [CHAN_W+LEVEL_W:0] product;
    logic [CHAN_W+LEVEL_W:0] shifted;
    logic                    unusedHighBits;

    // Full-width multiply, then drop the fractional LEVEL_W bits; the result
    // never exceeds the channel maximum so the upper bits are always zero.
    always_comb begin
        product = {{(LEVEL_W+1){1'b0}}, chan} * {{CHAN_W{1'b0}}, level};
        shifted = product >> LEVEL_W;
        scaled  = shifted[CHAN_W-1:0];
    end

    assign unusedHighBits = ^shifted[CHAN_W+LEVEL_W:CHAN_W];

endmodule

// File: rtl/screen_fade_mux.sv
// Routes one of several renderer colour streams to the VGA output. A change of
// the requested screen fades the current picture to black, swaps the source
// and fades back in, one brightness step per TICKS_PER_LEVEL frame ticks.
module screen_fade_mux #(
    parameter int NUM_SCREENS     = 4,
    parameter int RED_W           = screen_pkg::RED_W,
    parameter int GREEN_W         = screen_pkg::GREEN_W,
    parameter int BLUE_W          = screen_pkg::BLUE_W,
    parameter int LEVEL_W         = 3,
    parameter int TICKS_PER_LEVEL = 2,
    localparam int COLOR_W        = RED_W + GREEN_W + BLUE_W,
    localparam int SEL_W          = (NUM_SCREENS > 2) ? $clog2(NUM_SCREENS) : 1
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           FrameTick,
    input  logic [SEL_W-1:0]               Select,
    input  logic [NUM_SCREENS*COLOR_W-1:0] ColorIn,
    input  logic                           Blank,
    output logic [RED_W-1:0]               RedOut,
    output logic [GREEN_W-1:0]             GreenOut,
    output logic [BLUE_W-1:0]              BlueOut,
    output logic [SEL_W-1:0]               Active,
    output logic                           Busy
);

    localparam int TICK_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
    localparam logic [TICK_W-1:0]  LAST_TICK = TICK_W'(TICKS_PER_LEVEL - 1);
    localparam logic [LEVEL_W:0]   LMAX      = {1'b1, {LEVEL_W{1'b0}}};
    localparam logic [LEVEL_W:0]   LZERO     = '0;

    screen_pkg::fade_state_t state;
    logic [LEVEL_W:0]        level;
    logic [TICK_W-1:0]       tickCount;
    logic [SEL_W-1:0]        target;
    logic                    selectValid;
    logic                    stepNow;

    logic [COLOR_W-1:0]      source;
    logic [RED_W-1:0]        redScaled;
    logic [GREEN_W-1:0]      greenScaled;
    logic [BLUE_W-1:0]       blueScaled;

    // Screen indices beyond the configured count are silently ignored, and a
    // brightness step happens on the last frame tick of each pacing window.
    always_comb begin
        selectValid = (int'(Select) < NUM_SCREENS);
        stepNow     = FrameTick && (tickCount == LAST_TICK);
    end

    // Fade sequencer: owns the brightness level, tick pacing, latched target
    // and the routed screen; the counter restarts on every state change.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= screen_pkg::IDLE;
            level     <= LMAX;
            tickCount <= '0;
            target    <= '0;
            Active    <= '0;
            Busy      <= 1'b0;
        end else begin
            case (state)
                screen_pkg::IDLE: begin
                    if (Select != Active && selectValid) begin
                        target    <= Select;
                        state     <= screen_pkg::FADE_OUT;
                        tickCount <= '0;
                        Busy      <= 1'b1;
                    end
                end
                screen_pkg::FADE_OUT: begin
                    if (level == LZERO) begin
                        state     <= screen_pkg::SWAP;
                        tickCount <= '0;
                    end else if (stepNow) begin
                        level     <= level - 1'b1;
                        tickCount <= '0;
                        if (level == LZERO + 1'b1) begin
                            state <= screen_pkg::SWAP;
                        end
                    end else if (FrameTick) begin
                        tickCount <= tickCount + 1'b1;
                    end
                end
                screen_pkg::SWAP: begin
                    Active    <= target;
                    state     <= screen_pkg::FADE_IN;
                    tickCount <= '0;
                end
                screen_pkg::FADE_IN: begin
                    if (level == LMAX) begin
                        state     <= screen_pkg::IDLE;
                        tickCount <= '0;
                        Busy      <= 1'b0;
                    end else if (stepNow) begin
                        level     <= level + 1'b1;
                        tickCount <= '0;
                        if (level == LMAX - 1'b1) begin
                            state <= screen_pkg::IDLE;
                            Busy  <= 1'b0;
                        end
                    end else if (FrameTick) begin
                        tickCount <= tickCount + 1'b1;
                    end
                end
                default: begin
                    state     <= screen_pkg::IDLE;
                    tickCount <= '0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

    // Pick the colour word of the screen currently routed to the output.
    always_comb begin
        source = ColorIn[Active*COLOR_W +: COLOR_W];
    end

    color_scaler #(.CHAN_W(RED_W), .LEVEL_W(LEVEL_W)) redScaler (
        .chan   (source[BLUE_W+GREEN_W +: RED_W]),
        .level  (level),
        .scaled (redScaled)
    );

    color_scaler #(.CHAN_W(GREEN_W), .LEVEL_W(LEVEL_W)) greenScaler (
        .chan   (source[BLUE_W +: GREEN_W]),
        .level  (level),
        .scaled (greenScaled)
    );

    color_scaler #(.CHAN_W(BLUE_W), .LEVEL_W(LEVEL_W)) blueScaler (
        .chan   (source[BLUE_W-1:0]),
        .level  (level),
        .scaled (blueScaled)
    );

    // Single output register stage; blanking forces black without touching the fade.
    always_ff @(posedge Clock) begin
        if (Reset || Blank) begin
            RedOut   <= '0;
            GreenOut <= '0;
            BlueOut  <= '0;
        end else begin
            RedOut   <= redScaled;
            GreenOut <= greenScaled;
            BlueOut  <= blueScaled;
        end
    end

endmodule

// File: tb/tb_screen_fade_mux.sv
// Directed bench for screen_fade_mux: reset state, a full fade sequence with
// hand-worked colour values, select changes while busy, out-of-range select,
// blanking during a fade and reset in the middle of a fade.
module tb_screen_fade_mux;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        FrameTick;
    logic [1:0]  Select;
    logic [31:0] ColorIn;
    logic        Blank;
    logic [2:0]  redOut;
    logic [2:0]  greenOut;
    logic [1:0]  blueOut;
    logic [1:0]  active;
    logic        busy;

    logic [1:0]  select3;
    logic [23:0] colorIn3;
    logic [2:0]  redOut3;
    logic [2:0]  greenOut3;
    logic [1:0]  blueOut3;
    logic [1:0]  active3;
    logic        busy3;

    int total = 0;
    int bad   = 0;

    screen_fade_mux dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .FrameTick (FrameTick),
        .Select    (Select),
        .ColorIn   (ColorIn),
        .Blank     (Blank),
        .RedOut    (redOut),
        .GreenOut  (greenOut),
        .BlueOut   (blueOut),
        .Active    (active),
        .Busy      (busy)
    );

    screen_fade_mux #(.NUM_SCREENS(3)) dut3 (
        .Clock     (Clock),
        .Reset     (Reset),
        .FrameTick (FrameTick),
        .Select    (select3),
        .ColorIn   (colorIn3),
        .Blank     (Blank),
        .RedOut    (redOut3),
        .GreenOut  (greenOut3),
        .BlueOut   (blueOut3),
        .Active    (active3),
        .Busy      (busy3)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkRgb(input string tag, input int r, input int g, input int b);
        checkOutput({tag, " red"},   32'(redOut),   32'(r));
        checkOutput({tag, " green"}, 32'(greenOut), 32'(g));
        checkOutput({tag, " blue"},  32'(blueOut),  32'(b));
    endtask

    task automatic tickClock();
        @(posedge Clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic [1:0] sel, input logic tick, input logic blank);
        Reset     = rst;
        Select    = sel;
        FrameTick = tick;
        Blank     = blank;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        select3 = 2'd0;
        tickClock();
        tickClock();
        Reset = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tickClock();
            if (!busy) done = 1'b1;
        end
        checkOutput({tag, " idle reached"}, 32'(done), 32'd1);
    endtask

    // Transition 0 -> 2 with FrameTick every cycle; optional blanking on edges 26..30.
    task automatic runTransition(input bit withBlank);
        string t;
        t = withBlank ? "blank" : "fade";
        Select    = 2'd2;
        FrameTick = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            Blank = withBlank && (e >= 26) && (e <= 30);
            tickClock();
            case (e)
                1: begin
                    checkOutput({t, " busy rises"}, 32'(busy), 32'd1);
                    checkRgb({t, " e1"}, 7, 7, 3);
                end
                10: checkRgb({t, " out level4"}, 3, 3, 1);
                17: begin
                    checkOutput({t, " busy at swap"}, 32'(busy), 32'd1);
                    checkOutput({t, " active before swap"}, 32'(active), 32'd0);
                end
                18: begin
                    checkOutput({t, " active after swap"}, 32'(active), 32'd2);
                    checkRgb({t, " black at swap"}, 0, 0, 0);
                end
                25: checkRgb({t, " in level3"}, 1, 2, 0);
                26: if (withBlank) checkRgb({t, " e26"}, 0, 0, 0); else checkRgb({t, " e26"}, 1, 2, 0);
                27: if (withBlank) checkRgb({t, " e27"}, 0, 0, 0); else checkRgb({t, " e27"}, 2, 3, 1);
                30: if (withBlank) checkRgb({t, " e30"}, 0, 0, 0); else checkRgb({t, " e30"}, 3, 3, 1);
                31: checkRgb({t, " in level6"}, 3, 4, 1);
                33: checkOutput({t, " busy before end"}, 32'(busy), 32'd1);
                34: checkOutput({t, " busy falls"}, 32'(busy), 32'd0);
                35: begin
                    checkRgb({t, " screen2 full"}, 5, 6, 2);
                    checkOutput({t, " active final"}, 32'(active), 32'd2);
                end
                default: ;
            endcase
        end
        Blank = 1'b0;
    endtask

    initial begin
        ColorIn  = {8'h00, 8'hBA, 8'h24, 8'hFF};
        colorIn3 = {8'h00, 8'h00, 8'h49};

        // Reset state and first output
        doReset();
        checkRgb("reset", 0, 0, 0);
        checkOutput("reset active", 32'(active), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        tickClock();
        checkRgb("passthrough", 7, 7, 3);

        // Full fade out / swap / fade in
        runTransition(1'b0);

        // Blanking during fade in leaves the fade timing untouched
        doReset();
        runTransition(1'b1);

        // Select change while busy is ignored, picked up afterwards
        doReset();
        Select    = 2'd2;
        FrameTick = 1'b1;
        tickClock();
        tickClock();
        tickClock();
        Select = 2'd1;
        waitIdle("t3 first");
        checkOutput("t3 active first", 32'(active), 32'd2);
        tickClock();
        checkOutput("t3 second starts", 32'(busy), 32'd1);
        waitIdle("t3 second");
        checkOutput("t3 active second", 32'(active), 32'd1);

        // Out-of-range select on a three-screen instance
        doReset();
        select3 = 2'd3;
        for (int i = 0; i < 5; i++) tickClock();
        checkOutput("t4 busy", 32'(busy3), 32'd0);
        checkOutput("t4 active", 32'(active3), 32'd0);
        checkOutput("t4 red", 32'(redOut3), 32'd2);
        checkOutput("t4 green", 32'(greenOut3), 32'd2);
        checkOutput("t4 blue", 32'(blueOut3), 32'd1);
        select3 = 2'd1;
        tickClock();
        checkOutput("t4 valid select", 32'(busy3), 32'd1);

        // Reset in the middle of fade in
        doReset();
        Select    = 2'd2;
        FrameTick = 1'b1;
        for (int e = 1; e <= 25; e++) tickClock();
        checkOutput("t6 busy before", 32'(busy), 32'd1);
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        tickClock();
        checkRgb("t6 reset", 0, 0, 0);
        checkOutput("t6 active", 32'(active), 32'd0);
        checkOutput("t6 busy", 32'(busy), 32'd0);
        Reset = 1'b0;
        tickClock();
        checkRgb("t6 level restored", 7, 7, 3);
        checkOutput("t6 stays idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
